// File: rtl/pulse_meter_pkg.sv
// pulse_meter_pkg: shared state type and timing constants for the pulse period meter
package pulse_meter_pkg;
  typedef enum logic {IDLE, MEASURE} state_t;
  localparam int CLK_HZ = 50000000;
  localparam int DEFAULT_TIMEOUT = CLK_HZ;
  localparam int PERIOD_HALF_S = CLK_HZ / 2;
  localparam int PERIOD_QUARTER_S = CLK_HZ / 4;
  localparam int PERIOD_10MS = CLK_HZ / 100;
  localparam int PERIOD_1MS = CLK_HZ / 1000;
endpackage

// File: rtl/pm_rise_detect.sv
// pm_rise_detect: registered history plus AND giving a same-cycle rising-edge pulse
module pm_rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_rise
);
  logic r_prev;
  always_ff @(posedge clk or posedge reset)
    if (reset) r_prev <= 1'b0;
    else r_prev <= i_d;
  assign o_rise = i_d & ~r_prev;
endmodule

// File: rtl/pulse_period_meter.sv
// pulse_period_meter: cycles between rising edges of event_in, with valid and timeout strobes
// PERIOD_MINMAX_EN adds stats_clr and running min_period/max_period registers.
module pulse_period_meter
  import pulse_meter_pkg::*;
#(
  parameter int CNT_W = 26,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             event_in,
`ifdef PERIOD_MINMAX_EN
  input  logic             stats_clr,
  output logic [CNT_W-1:0] min_period,
  output logic [CNT_W-1:0] max_period,
`endif
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             timeout,
  output logic             busy
);
  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);
  state_t r_state, w_state_nx;
  logic [CNT_W-1:0] r_count, w_count_nx, r_period, w_period_nx;
  logic r_valid, w_valid_nx, r_timeout, w_timeout_nx, w_ev;
  pm_rise_detect u_rise (
    .clk    (clk),
    .reset  (reset),
    .i_d    (event_in),
    .o_rise (w_ev)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_state   <= IDLE;
      r_count   <= '0;
      r_period  <= '0;
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_count   <= w_count_nx;
      r_period  <= w_period_nx;
      r_valid   <= w_valid_nx;
      r_timeout <= w_timeout_nx;
    end
  // An edge coinciding with count==TIMEOUT is still a valid measurement.
  always_comb begin
    w_state_nx   = r_state;
    w_count_nx   = r_count;
    w_period_nx  = r_period;
    w_valid_nx   = 1'b0;
    w_timeout_nx = 1'b0;
    if (!enable) begin
      w_state_nx = IDLE;
      w_count_nx = '0;
    end else if (r_state == IDLE) begin
      w_state_nx = w_ev ? MEASURE : IDLE;
      w_count_nx = w_ev ? CNT_W'(1) : '0;
    end else if (w_ev) begin
      w_period_nx = r_count;
      w_valid_nx  = 1'b1;
      w_count_nx  = CNT_W'(1);
    end else if (r_count == TMO) begin
      w_timeout_nx = 1'b1;
      w_state_nx   = IDLE;
      w_count_nx   = '0;
    end else begin
      w_count_nx = r_count + 1'b1;
    end
  end
  assign period       = r_period;
  assign period_valid = r_valid;
  assign timeout      = r_timeout;
  assign busy         = (r_state == MEASURE);
`ifdef PERIOD_MINMAX_EN
  logic [CNT_W-1:0] r_min, r_max;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_min <= '1;
      r_max <= '0;
    end else if (stats_clr) begin
      r_min <= '1;
      r_max <= '0;
    end else if (w_valid_nx) begin
      r_min <= (w_period_nx < r_min) ? w_period_nx : r_min;
      r_max <= (w_period_nx > r_max) ? w_period_nx : r_max;
    end
  assign min_period = r_min;
  assign max_period = r_max;
`endif
endmodule
